// File: rtl/custom_rd_fwft_buf.sv
// custom_rd_fwft_buf: FWFT read stage of the async FIFO; a 2-entry skid buffer
// decouples ren from the consumer's m_ready.
module custom_rd_fwft_buf #(
    parameter int DATASIZE = 8
) (
    input  logic                rclk_i,
    input  logic                rrst_n_i,
    input  logic                fifo_empty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                ren,
    input  logic                flush_i,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    input  logic                m_ready,
    output logic [1:0]          buf_level
);
    logic [1:0]          count_q, count_d;
    logic [DATASIZE-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic                push, pop;

    // ren depends only on local state, never on m_ready
    assign push      = ~fifo_empty & (count_q < 2'd2) & ~flush_i & rrst_n_i;
    assign pop       = (count_q != 2'd0) & m_ready & ~flush_i;
    assign ren       = push;
    assign m_valid   = count_q != 2'd0;
    assign m_data    = slot0_q;
    assign buf_level = count_q;

    always_comb begin
        count_d = flush_i ? 2'd0 : count_q + {1'b0, push & ~pop} - {1'b0, pop & ~push};
        slot0_d = push && (count_q == 2'd0 || pop) ? rdata : pop ? slot1_q : slot0_q;
        slot1_d = push && !pop && count_q == 2'd1 ? rdata : slot1_q;
    end

    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            count_q <= '0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end
endmodule
